// File: rtl/vram_pkg.sv
// Shared types for the text-VRAM write-port arbiter.
//   ADDR_W_DEF / DATA_W_DEF : default VRAM address / data widths
//   eng_state_t             : fill-engine state (idle, boot pattern fill, fill command)
//   vram_wr_t               : one VRAM write (address + data) at the default widths
package vram_pkg;

  localparam int unsigned ADDR_W_DEF = 10;
  localparam int unsigned DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    ENG_IDLE,
    ENG_BOOT,
    ENG_FILL
  } eng_state_t;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] data;
  } vram_wr_t;

endpackage

// File: rtl/vram_fill_engine.sv
// Fill engine: boot test-pattern fill after reset and clear/fill commands.
// Presents one pending write (addr/data) at a time; the arbiter consumes it with `advance`.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   fill_start        1-cycle pulse; start a fill (ignored unless idle)
//   fill_base/len/value/incr  fill command parameters, latched on an accepted start
//   advance           the pending write was granted this cycle
//   pending           a write is waiting for the port
//   addr, data        the pending write
//   busy              engine in BOOT or FILL
//   fill_done         1-cycle pulse, one cycle after the last fill write hits the port
//   boot_done         sticky, set together with the last boot write
module vram_fill_engine
  import vram_pkg::*;
#(
  parameter int unsigned       ADDR_W    = ADDR_W_DEF,
  parameter int unsigned       DATA_W    = DATA_W_DEF,
  parameter bit                BOOT_FILL = 1'b1,
  parameter logic [DATA_W-1:0] BOOT_MASK = 'h7F
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fill_start,
  input  logic [ADDR_W-1:0] fill_base,
  input  logic [ADDR_W:0]   fill_len,
  input  logic [DATA_W-1:0] fill_value,
  input  logic              fill_incr,
  input  logic              advance,
  output logic              pending,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data,
  output logic              busy,
  output logic              fill_done,
  output logic              boot_done
);

  localparam logic [ADDR_W:0] DEPTH_CNT = {1'b1, {ADDR_W{1'b0}}};
  localparam eng_state_t      RST_STATE = BOOT_FILL ? ENG_BOOT : ENG_IDLE;

  eng_state_t        state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              incr_q;
  logic [ADDR_W:0]   cnt_q;      // writes still to issue
  logic              last_q;     // last fill write granted last cycle
  logic              done_q;
  logic              boot_done_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RST_STATE;
      addr_q      <= '0;
      data_q      <= '0;
      incr_q      <= 1'b0;
      cnt_q       <= DEPTH_CNT;
      last_q      <= 1'b0;
      done_q      <= 1'b0;
      boot_done_q <= ~BOOT_FILL;
    end else begin
      // fill_done trails the final write's v_cea by one cycle
      done_q <= last_q;
      last_q <= 1'b0;
      case (state_q)
        ENG_IDLE: begin
          if (fill_start) begin
            addr_q <= fill_base;
            data_q <= fill_value;
            incr_q <= fill_incr;
            cnt_q  <= fill_len;
            if (fill_len == '0) begin
              done_q <= 1'b1;
            end else begin
              state_q <= ENG_FILL;
            end
          end
        end
        ENG_BOOT: begin
          if (advance) begin
            addr_q <= addr_q + ADDR_W'(1);
            cnt_q  <= cnt_q - (ADDR_W + 1)'(1);
            if (cnt_q == (ADDR_W + 1)'(1)) begin
              state_q     <= ENG_IDLE;
              boot_done_q <= 1'b1;
            end
          end
        end
        ENG_FILL: begin
          if (advance) begin
            addr_q <= addr_q + ADDR_W'(1);
            if (incr_q) data_q <= data_q + DATA_W'(1);
            cnt_q <= cnt_q - (ADDR_W + 1)'(1);
            if (cnt_q == (ADDR_W + 1)'(1)) begin
              state_q <= ENG_IDLE;
              last_q  <= 1'b1;
            end
          end
        end
        default: state_q <= ENG_IDLE;
      endcase
    end
  end

  assign pending   = (state_q != ENG_IDLE);
  assign busy      = (state_q != ENG_IDLE);
  assign addr      = addr_q;
  assign data      = (state_q == ENG_BOOT) ? (DATA_W'(addr_q) & BOOT_MASK) : data_q;
  assign fill_done = done_q;
  assign boot_done = boot_done_q;

endmodule

// File: rtl/vram_write_arbiter.sv
// Owner of the text-VRAM write port. Shares it between CPU writes and the fill engine,
// issuing at most one registered write per cycle.
// Ports:
//   MEMORY_CLK, rst               clock, asynchronous active-high reset
//   cpu_req/cpu_addr/cpu_data     CPU write request, held until cpu_ack
//   cpu_ack                       1-cycle pulse, the CPU write is on the port this cycle
//   fill_start/base/len/value/incr  fill command
//   fill_busy, fill_done, boot_done engine status
//   v_cea, v_ada, v_din           registered VRAM write port
module vram_write_arbiter
  import vram_pkg::*;
#(
  parameter int unsigned       ADDR_W    = ADDR_W_DEF,
  parameter int unsigned       DATA_W    = DATA_W_DEF,
  parameter bit                BOOT_FILL = 1'b1,
  parameter logic [DATA_W-1:0] BOOT_MASK = 'h7F
) (
  input  logic              MEMORY_CLK,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_data,
  output logic              cpu_ack,
  input  logic              fill_start,
  input  logic [ADDR_W-1:0] fill_base,
  input  logic [ADDR_W:0]   fill_len,
  input  logic [DATA_W-1:0] fill_value,
  input  logic              fill_incr,
  output logic              fill_busy,
  output logic              fill_done,
  output logic              boot_done,
  output logic              v_cea,
  output logic [ADDR_W-1:0] v_ada,
  output logic [DATA_W-1:0] v_din
);

  logic              eng_pending;
  logic [ADDR_W-1:0] eng_addr;
  logic [DATA_W-1:0] eng_data;
  logic              cpu_elig;
  logic              contested;
  logic              grant_cpu;
  logic              grant_eng;

  logic              cpu_ack_q;
  logic              v_cea_q;
  logic [ADDR_W-1:0] v_ada_q;
  logic [DATA_W-1:0] v_din_q;
  logic              last_grant_q;  // 1: CPU won the last contested cycle

  vram_fill_engine #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .BOOT_FILL (BOOT_FILL),
    .BOOT_MASK (BOOT_MASK)
  ) u_engine (
    .clk        (MEMORY_CLK),
    .rst        (rst),
    .fill_start (fill_start),
    .fill_base  (fill_base),
    .fill_len   (fill_len),
    .fill_value (fill_value),
    .fill_incr  (fill_incr),
    .advance    (grant_eng),
    .pending    (eng_pending),
    .addr       (eng_addr),
    .data       (eng_data),
    .busy       (fill_busy),
    .fill_done  (fill_done),
    .boot_done  (boot_done)
  );

  always_comb begin
    // A request still high in the ack cycle is the one just served, not a new one
    cpu_elig  = cpu_req & ~cpu_ack_q;
    contested = cpu_elig & eng_pending;
    grant_cpu = cpu_elig & (~eng_pending | ~last_grant_q);
    grant_eng = eng_pending & ~grant_cpu;
  end

  always_ff @(posedge MEMORY_CLK or posedge rst) begin
    if (rst) begin
      cpu_ack_q    <= 1'b0;
      v_cea_q      <= 1'b0;
      v_ada_q      <= '0;
      v_din_q      <= '0;
      last_grant_q <= 1'b0;
    end else begin
      cpu_ack_q <= grant_cpu;
      v_cea_q   <= grant_cpu | grant_eng;
      if (grant_cpu) begin
        v_ada_q <= cpu_addr;
        v_din_q <= cpu_data;
      end else if (grant_eng) begin
        v_ada_q <= eng_addr;
        v_din_q <= eng_data;
      end
      if (contested) last_grant_q <= ~last_grant_q;
    end
  end

  assign cpu_ack = cpu_ack_q;
  assign v_cea   = v_cea_q;
  assign v_ada   = v_ada_q;
  assign v_din   = v_din_q;

endmodule

// File: tb/tb_vram_write_arbiter.sv
// Bench for vram_write_arbiter: expected writes are queued per source (CPU / engine) when
// stimulus is driven and popped by a port monitor whenever v_cea is seen.
module tb_vram_write_arbiter;
  import vram_pkg::*;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEPTH  = 1024;

  logic              MEMORY_CLK = 1'b0;
  logic              rst        = 1'b1;
  logic              cpu_req    = 1'b0;
  logic [ADDR_W-1:0] cpu_addr   = '0;
  logic [DATA_W-1:0] cpu_data   = '0;
  logic              cpu_ack;
  logic              fill_start = 1'b0;
  logic [ADDR_W-1:0] fill_base  = '0;
  logic [ADDR_W:0]   fill_len   = '0;
  logic [DATA_W-1:0] fill_value = '0;
  logic              fill_incr  = 1'b0;
  logic              fill_busy;
  logic              fill_done;
  logic              boot_done;
  logic              v_cea;
  logic [ADDR_W-1:0] v_ada;
  logic [DATA_W-1:0] v_din;

  vram_wr_t exp_cpu[$];
  vram_wr_t exp_eng[$];
  int n_checks = 0;
  int n_fail   = 0;

  always #5 MEMORY_CLK = ~MEMORY_CLK;

  vram_write_arbiter #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .BOOT_FILL (1'b1),
    .BOOT_MASK (8'h7F)
  ) dut (
    .MEMORY_CLK (MEMORY_CLK),
    .rst        (rst),
    .cpu_req    (cpu_req),
    .cpu_addr   (cpu_addr),
    .cpu_data   (cpu_data),
    .cpu_ack    (cpu_ack),
    .fill_start (fill_start),
    .fill_base  (fill_base),
    .fill_len   (fill_len),
    .fill_value (fill_value),
    .fill_incr  (fill_incr),
    .fill_busy  (fill_busy),
    .fill_done  (fill_done),
    .boot_done  (boot_done),
    .v_cea      (v_cea),
    .v_ada      (v_ada),
    .v_din      (v_din)
  );

  // Port monitor: every write must match the head of its source's queue
  always @(negedge MEMORY_CLK) begin
    vram_wr_t got;
    vram_wr_t want;
    got = '{addr: v_ada, data: v_din};
    if (v_cea) begin
      n_checks++;
      if (cpu_ack) begin
        if (exp_cpu.size() == 0) begin
          n_fail++;
          $display("FAIL cpu_write_unexpected: got %h expected none", got);
        end else begin
          want = exp_cpu.pop_front();
          if (got !== want) begin
            n_fail++;
            $display("FAIL cpu_write: got %h expected %h", got, want);
          end
        end
      end else begin
        if (exp_eng.size() == 0) begin
          n_fail++;
          $display("FAIL eng_write_unexpected: got %h expected none", got);
        end else begin
          want = exp_eng.pop_front();
          if (got !== want) begin
            n_fail++;
            $display("FAIL eng_write: got %h expected %h", got, want);
          end
        end
      end
    end else if (cpu_ack) begin
      n_checks++;
      n_fail++;
      $display("FAIL ack_without_write: got cpu_ack=1 v_cea=0 expected v_cea=1");
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // Called at a negedge with rst high; releases rst and checks the full boot fill.
  task automatic test_boot_sequence(input bit poke);
    int gaps;
    int dones;
    int extra;
    int early;
    gaps = 0; dones = 0; extra = 0; early = 0;
    exp_eng.delete();
    for (int i = 0; i < DEPTH; i++) begin
      logic [ADDR_W-1:0] a;
      a = ADDR_W'(i);
      exp_eng.push_back('{addr: a, data: a[7:0] & 8'h7F});
    end
    rst = 1'b0;
    for (int k = 1; k <= DEPTH; k++) begin
      @(negedge MEMORY_CLK);
      if (!v_cea) gaps++;
      if (fill_done) dones++;
      if (k < DEPTH && boot_done) early++;
      if (poke && k == 10) begin
        fill_start = 1'b1; fill_base = 10'h000; fill_len = 11'd5;
        fill_value = 8'hEE; fill_incr = 1'b0;
      end
      if (k == 11) fill_start = 1'b0;
    end
    n_checks++;
    if (gaps !== 0) begin n_fail++; $display("FAIL boot_gapless: got %0d gaps expected 0", gaps); end
    n_checks++;
    if (early !== 0) begin n_fail++; $display("FAIL boot_done_early: got %0d expected 0", early); end
    n_checks++;
    if (boot_done !== 1'b1) begin n_fail++; $display("FAIL boot_done: got %b expected 1", boot_done); end
    n_checks++;
    if (fill_busy !== 1'b0) begin n_fail++; $display("FAIL boot_busy_end: got %b expected 0", fill_busy); end
    repeat (12) begin
      @(negedge MEMORY_CLK);
      if (v_cea) extra++;
      if (fill_done) dones++;
    end
    n_checks++;
    if (extra !== 0) begin n_fail++; $display("FAIL boot_extra_writes: got %0d expected 0", extra); end
    n_checks++;
    if (dones !== 0) begin n_fail++; $display("FAIL boot_fill_done: got %0d expected 0", dones); end
    n_checks++;
    if (exp_eng.size() !== 0) begin
      n_fail++; $display("FAIL boot_count: got %0d left expected 0", exp_eng.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge MEMORY_CLK);
    n_checks++;
    if ({v_cea, cpu_ack, fill_done} !== 3'b000) begin
      n_fail++; $display("FAIL reset_pulses: got %b expected 000", {v_cea, cpu_ack, fill_done});
    end
    n_checks++;
    if ({v_ada, v_din} !== 18'h0) begin
      n_fail++; $display("FAIL reset_port: got %h expected 0", {v_ada, v_din});
    end
    n_checks++;
    if ({boot_done, fill_busy} !== 2'b01) begin
      n_fail++; $display("FAIL reset_status: got %b expected 01", {boot_done, fill_busy});
    end
    test_boot_sequence(1'b0);
  endtask

  task automatic test_cpu_single();
    int lat;
    bit got;
    lat = 0; got = 1'b0;
    @(negedge MEMORY_CLK);
    cpu_req = 1'b1; cpu_addr = 10'h123; cpu_data = 8'h41;
    exp_cpu.push_back('{addr: 10'h123, data: 8'h41});
    for (int k = 1; k <= 8 && !got; k++) begin
      @(negedge MEMORY_CLK);
      if (cpu_ack) begin got = 1'b1; lat = k; cpu_req = 1'b0; end
    end
    n_checks++;
    if (!got || lat !== 1) begin
      n_fail++; $display("FAIL cpu_latency: got %0d expected 1", lat);
      cpu_req = 1'b0;
    end
    @(negedge MEMORY_CLK);
    n_checks++;
    if ({cpu_ack, v_cea} !== 2'b00) begin
      n_fail++; $display("FAIL cpu_ack_pulse: got %b expected 00", {cpu_ack, v_cea});
    end
    n_checks++;
    if ({v_ada, v_din} !== {10'h123, 8'h41}) begin
      n_fail++; $display("FAIL port_hold: got %h expected %h", {v_ada, v_din}, {10'h123, 8'h41});
    end
  endtask

  task automatic test_fill_wrap();
    logic [7:0] cea_pat;
    logic [7:0] done_pat;
    logic       busy1;
    cea_pat = '0; done_pat = '0; busy1 = 1'b0;
    @(negedge MEMORY_CLK);
    fill_start = 1'b1; fill_base = 10'h3FE; fill_len = 11'd4; fill_value = 8'hFE; fill_incr = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_eng.push_back('{addr: 10'h3FE + ADDR_W'(i), data: 8'hFE + DATA_W'(i)});
    end
    for (int k = 1; k <= 8; k++) begin
      @(negedge MEMORY_CLK);
      if (k == 1) begin fill_start = 1'b0; busy1 = fill_busy; end
      cea_pat[k-1]  = v_cea;
      done_pat[k-1] = fill_done;
    end
    n_checks++;
    if (busy1 !== 1'b1) begin n_fail++; $display("FAIL fill_busy: got %b expected 1", busy1); end
    n_checks++;
    if (cea_pat !== 8'b0001_1110) begin
      n_fail++; $display("FAIL fill_cea_timing: got %b expected 00011110", cea_pat);
    end
    n_checks++;
    if (done_pat !== 8'b0010_0000) begin
      n_fail++; $display("FAIL fill_done_timing: got %b expected 00100000", done_pat);
    end
    n_checks++;
    if (exp_eng.size() !== 0) begin
      n_fail++; $display("FAIL fill_count: got %0d left expected 0", exp_eng.size());
    end
  endtask

  task automatic test_contention();
    int eng_wr, n_ack, last_e, last_c, max_gap_e, max_int_c, ci;
    bit done_seen, stop;
    eng_wr = 0; n_ack = 0; last_e = 0; last_c = 0; max_gap_e = 0; max_int_c = 0; ci = 0;
    done_seen = 1'b0; stop = 1'b0;
    @(negedge MEMORY_CLK);
    fill_start = 1'b1; fill_base = 10'h100; fill_len = 11'd8; fill_value = 8'h5A; fill_incr = 1'b0;
    for (int i = 0; i < 8; i++) exp_eng.push_back('{addr: 10'h100 + ADDR_W'(i), data: 8'h5A});
    cpu_req = 1'b1; cpu_addr = 10'h200; cpu_data = 8'hC0;
    exp_cpu.push_back('{addr: 10'h200, data: 8'hC0});
    for (int k = 1; k <= 60 && !stop; k++) begin
      @(negedge MEMORY_CLK);
      if (k == 1) fill_start = 1'b0;
      if (v_cea && !cpu_ack) begin
        eng_wr++;
        if (last_e > 0 && k - last_e - 1 > max_gap_e) max_gap_e = k - last_e - 1;
        last_e = k;
      end
      if (cpu_ack) begin
        n_ack++;
        if (last_c > 0 && k - last_c > max_int_c) max_int_c = k - last_c;
        last_c = k;
        if (done_seen) begin
          cpu_req = 1'b0; stop = 1'b1;
        end else begin
          ci++;
          cpu_addr = 10'h200 + ADDR_W'(ci); cpu_data = 8'hC0 + DATA_W'(ci);
          exp_cpu.push_back('{addr: cpu_addr, data: cpu_data});
        end
      end
      if (fill_done) done_seen = 1'b1;
    end
    cpu_req = 1'b0;
    @(negedge MEMORY_CLK);
    n_checks++;
    if (!stop) begin n_fail++; $display("FAIL contention_end: got timeout expected done+ack"); end
    n_checks++;
    if (eng_wr !== 8) begin n_fail++; $display("FAIL contention_fill_count: got %0d expected 8", eng_wr); end
    n_checks++;
    if (max_gap_e > 1) begin n_fail++; $display("FAIL contention_fill_gap: got %0d expected <=1", max_gap_e); end
    n_checks++;
    if (max_int_c > 3) begin n_fail++; $display("FAIL contention_cpu_interval: got %0d expected <=3", max_int_c); end
    n_checks++;
    if (n_ack < 3) begin n_fail++; $display("FAIL contention_cpu_acks: got %0d expected >=3", n_ack); end
    n_checks++;
    if (exp_cpu.size() !== 0 || exp_eng.size() !== 0) begin
      n_fail++; $display("FAIL contention_queues: got %0d/%0d left expected 0/0", exp_cpu.size(), exp_eng.size());
    end
  endtask

  task automatic test_zero_len();
    @(negedge MEMORY_CLK);
    fill_start = 1'b1; fill_base = 10'h055; fill_len = 11'd0; fill_value = 8'h11; fill_incr = 1'b0;
    @(negedge MEMORY_CLK);
    fill_start = 1'b0;
    n_checks++;
    if ({fill_done, fill_busy, v_cea} !== 3'b100) begin
      n_fail++; $display("FAIL zero_len_done: got %b expected 100", {fill_done, fill_busy, v_cea});
    end
    @(negedge MEMORY_CLK);
    n_checks++;
    if ({fill_done, fill_busy, v_cea} !== 3'b000) begin
      n_fail++; $display("FAIL zero_len_after: got %b expected 000", {fill_done, fill_busy, v_cea});
    end
  endtask

  task automatic test_reset_mid_fill();
    int wr;
    bit hit;
    wr = 0; hit = 1'b0;
    @(negedge MEMORY_CLK);
    fill_start = 1'b1; fill_base = 10'h040; fill_len = 11'd8; fill_value = 8'h30; fill_incr = 1'b1;
    for (int i = 0; i < 8; i++) begin
      exp_eng.push_back('{addr: 10'h040 + ADDR_W'(i), data: 8'h30 + DATA_W'(i)});
    end
    for (int k = 1; k <= 20 && !hit; k++) begin
      @(negedge MEMORY_CLK);
      if (k == 1) fill_start = 1'b0;
      if (v_cea) wr++;
      if (wr == 3) hit = 1'b1;
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (!hit) begin n_fail++; $display("FAIL mid_fill_reach: got %0d writes expected 3", wr); end
    n_checks++;
    if ({v_cea, cpu_ack, fill_done, boot_done, fill_busy} !== 5'b00001) begin
      n_fail++;
      $display("FAIL async_reset_status: got %b expected 00001",
               {v_cea, cpu_ack, fill_done, boot_done, fill_busy});
    end
    n_checks++;
    if ({v_ada, v_din} !== 18'h0) begin
      n_fail++; $display("FAIL async_reset_port: got %h expected 0", {v_ada, v_din});
    end
    exp_eng.delete();
    @(negedge MEMORY_CLK);
    test_boot_sequence(1'b1);
  endtask

  initial begin
    test_reset();
    test_cpu_single();
    test_fill_wrap();
    test_contention();
    test_zero_len();
    test_reset_mid_fill();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
